dcache_m: RTL and testbench

//   Data-memory responder at the far end of the core's Dcache port (o_DcacheAddr/o_data/o_we -> i_DcacheData).

---
 rtl/dcache_m_pkg.sv | 50 +++++
 rtl/dcache_m_if.sv | 23 ++
 rtl/dcache_m_lane_ext.sv | 26 ++
 rtl/dcache_m.sv | 121 ++++++++++++
 tb/tb_dcache_m.sv | 348 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dcache_m_pkg.sv
// Shared definitions for the data-memory responder: funct3 codes, pipeline slot payload,
// and the lane-mask / misalignment / store-replication helpers.
package dcache_m_pkg;

    localparam int unsigned WORD_W = 32;

    localparam logic [2:0] MEM_B  = 3'b000;
    localparam logic [2:0] MEM_H  = 3'b001;
    localparam logic [2:0] MEM_W  = 3'b010;
    localparam logic [2:0] MEM_BU = 3'b100;
    localparam logic [2:0] MEM_HU = 3'b101;

    // One pipeline slot: what the final stage needs to build a response.
    typedef struct packed {
        logic              load;
        logic              mis;
        logic [2:0]        func;
        logic [1:0]        off;
        logic [WORD_W-1:0] word;
    } slot_t;

    // Illegal funct3 encodings count as misaligned so they are suppressed the same way.
    function automatic logic access_misaligned(input logic [2:0] func, input logic [1:0] off);
        case (func)
            MEM_B, MEM_BU: return 1'b0;
            MEM_H, MEM_HU: return off[0];
            MEM_W:         return off != 2'b00;
            default:       return 1'b1;
        endcase
    endfunction

    function automatic logic [3:0] lane_mask(input logic [2:0] func, input logic [1:0] off);
        case (func)
            MEM_B, MEM_BU: return 4'(4'b0001 << off);
            MEM_H, MEM_HU: return 4'(4'b0011 << {off[1], 1'b0});
            MEM_W:         return 4'b1111;
            default:       return 4'b0000;
        endcase
    endfunction

    function automatic logic [WORD_W-1:0] store_replicate(input logic [2:0] func,
                                                          input logic [WORD_W-1:0] data);
        case (func)
            MEM_B, MEM_BU: return {4{data[7:0]}};
            MEM_H, MEM_HU: return {2{data[15:0]}};
            default:       return data;
        endcase
    endfunction

endpackage

// File: rtl/dcache_m_if.sv
// Core-side data port bundle: request fields in, load response out.
interface dcache_m_if #(
    parameter int unsigned ADDR_WIDTH = 32
) ();
    logic                  i_req;
    logic                  i_we;
    logic [2:0]            i_func;
    logic [ADDR_WIDTH-1:0] i_addr;
    logic [31:0]           i_data;
    logic [31:0]           o_data;
    logic                  o_valid;
    logic                  o_misalign;

    modport master (
        output i_req, i_we, i_func, i_addr, i_data,
        input  o_data, o_valid, o_misalign
    );

    modport slave (
        input  i_req, i_we, i_func, i_addr, i_data,
        output o_data, o_valid, o_misalign
    );
endinterface

// File: rtl/dcache_m_lane_ext.sv
// Combinational load lane extraction: picks byte/half/word from the array word and extends it.
module dcache_m_lane_ext
    import dcache_m_pkg::*;
(
    input  logic [2:0]        i_func,
    input  logic [1:0]        i_off,
    input  logic [WORD_W-1:0] i_word,
    output logic [WORD_W-1:0] o_res_c
);
    logic [7:0]  byte_c;
    logic [15:0] half_c;

    always_comb begin
        byte_c  = i_word[{i_off, 3'b000} +: 8];
        half_c  = i_word[{i_off[1], 4'b0000} +: 16];
        o_res_c = '0;
        case (i_func)
            MEM_B:   o_res_c = {{24{byte_c[7]}}, byte_c};
            MEM_BU:  o_res_c = {24'h0, byte_c};
            MEM_H:   o_res_c = {{16{half_c[15]}}, half_c};
            MEM_HU:  o_res_c = {16'h0, half_c};
            MEM_W:   o_res_c = i_word;
            default: o_res_c = '0;
        endcase
    end
endmodule

// File: rtl/dcache_m.sv
// Data-memory responder: word array with byte-lane stores and fixed-latency pipelined loads.
module dcache_m
    import dcache_m_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DEPTH      = 1024,
    parameter int unsigned LATENCY    = 2
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    dcache_m_if.slave  bus
);
    localparam int unsigned IDX_W = $clog2(DEPTH);

    logic [WORD_W-1:0] mem_q [DEPTH];

    logic [IDX_W-1:0]  idx_c;
    logic [1:0]        off_c;
    logic              mis_c;
    logic [3:0]        be_c;
    logic [WORD_W-1:0] wdata_c;
    slot_t             req_c;
    slot_t             fin_c;
    logic [WORD_W-1:0] ext_c;
    logic              unused_c;

    logic              o_valid_d, o_valid_q;
    logic              o_mis_d,   o_mis_q;
    logic [WORD_W-1:0] o_data_d,  o_data_q;

    assign idx_c    = bus.i_addr[2 +: IDX_W];
    assign off_c    = bus.i_addr[1:0];
    assign mis_c    = access_misaligned(bus.i_func, off_c);
    assign unused_c = ^bus.i_addr[ADDR_WIDTH-1:2+IDX_W];

    // Store enables; a store landing on a reset edge is dropped.
    always_comb begin
        be_c    = '0;
        wdata_c = store_replicate(bus.i_func, bus.i_data);
        if (bus.i_req && bus.i_we && !mis_c && i_rst_n) begin
            be_c = lane_mask(bus.i_func, off_c);
        end
    end

    always_ff @(posedge i_clk) begin
        for (int b = 0; b < 4; b++) begin
            if (be_c[b]) begin
                mem_q[idx_c][8*b +: 8] <= wdata_c[8*b +: 8];
            end
        end
    end

    // Stage-1 payload: array read happens before this edge's store lands.
    always_comb begin
        req_c      = '0;
        req_c.load = bus.i_req && !bus.i_we;
        req_c.mis  = bus.i_req && mis_c;
        req_c.func = bus.i_func;
        req_c.off  = off_c;
        req_c.word = mem_q[idx_c];
    end

    generate
        if (LATENCY == 1) begin : g_lat1
            assign fin_c = req_c;
        end else begin : g_pipe
            slot_t pipe_q [LATENCY-1];
            slot_t pipe_d [LATENCY-1];

            always_comb begin
                pipe_d[0] = req_c;
                for (int i = 1; i < int'(LATENCY) - 1; i++) begin
                    pipe_d[i] = pipe_q[i-1];
                end
            end

            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    for (int i = 0; i < int'(LATENCY) - 1; i++) pipe_q[i] <= '0;
                end else begin
                    for (int i = 0; i < int'(LATENCY) - 1; i++) pipe_q[i] <= pipe_d[i];
                end
            end

            assign fin_c = pipe_q[LATENCY-2];
        end
    endgenerate

    dcache_m_lane_ext u_lane_ext (
        .i_func  (fin_c.func),
        .i_off   (fin_c.off),
        .i_word  (fin_c.word),
        .o_res_c (ext_c)
    );

    // Response register; o_data only changes on a load response.
    always_comb begin
        o_valid_d = fin_c.load;
        o_mis_d   = fin_c.mis;
        o_data_d  = o_data_q;
        if (fin_c.load) begin
            o_data_d = fin_c.mis ? '0 : ext_c;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_valid_q <= 1'b0;
            o_mis_q   <= 1'b0;
            o_data_q  <= '0;
        end else begin
            o_valid_q <= o_valid_d;
            o_mis_q   <= o_mis_d;
            o_data_q  <= o_data_d;
        end
    end

    assign bus.o_valid    = o_valid_q;
    assign bus.o_misalign = o_mis_q;
    assign bus.o_data     = o_data_q;
endmodule

// File: tb/tb_dcache_m.sv
// Self-checking bench for dcache_m: directed scenarios plus randomized traffic against a byte-level memory model.
module tb_dcache_m;
    localparam int unsigned AW    = 32;
    localparam int unsigned DEPTH = 1024;
    localparam int unsigned LAT   = 2;

    typedef struct {
        logic        req;
        logic        we;
        logic [2:0]  f;
        logic [31:0] a;
        logic [31:0] d;
    } rq_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dcache_m_if #(.ADDR_WIDTH(AW)) bus ();

    dcache_m #(.ADDR_WIDTH(AW), .DEPTH(DEPTH), .LATENCY(LAT)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc   = 0;
    logic [31:0] mmem [DEPTH];
    bit          ev [64];
    bit          em [64];
    logic [31:0] ed [64];
    logic [31:0] hold = '0;

    function automatic int fsize(input logic [2:0] f);
        case (f)
            3'd0, 3'd4: return 1;
            3'd1, 3'd5: return 2;
            3'd2:       return 4;
            default:    return 0;
        endcase
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 64; i++) begin
            ev[i] = 1'b0;
            em[i] = 1'b0;
        end
        hold = '0;
    endtask

    // Reference: apply the access to a plain memory and schedule its response slot.
    task automatic model_issue(input logic we, input logic [2:0] f, input logic [31:0] a,
                               input logic [31:0] d, input int slot);
        int sz;
        int idx;
        int off;
        bit mis;
        logic [31:0] v;
        sz  = fsize(f);
        idx = int'((a >> 2) % DEPTH);
        off = int'(a % 4);
        mis = (sz == 0) || ((off % sz) != 0);
        em[slot % 64] = mis;
        if (we) begin
            if (!mis) for (int k = 0; k < sz; k++) mmem[idx][8*(off+k) +: 8] = d[8*k +: 8];
        end else begin
            ev[slot % 64] = 1'b1;
            v = mmem[idx] >> (8 * off);
            if (mis)         v = 32'h0;
            else if (sz == 1) v = f[2] ? {24'h0, v[7:0]}  : {{24{v[7]}}, v[7:0]};
            else if (sz == 2) v = f[2] ? {16'h0, v[15:0]} : {{16{v[15]}}, v[15:0]};
            ed[slot % 64] = v;
        end
    endtask

    // Drive one cycle, then return what the model expects to observe at the following negedge.
    task automatic step(input rq_t r, output logic xv, output logic [31:0] xd, output logic xm);
        bus.i_req  = r.req;
        bus.i_we   = r.we;
        bus.i_func = r.f;
        bus.i_addr = r.a;
        bus.i_data = r.d;
        @(posedge clk);
        cyc++;
        if (!rst_n) model_reset();
        else if (r.req) model_issue(r.we, r.f, r.a, r.d, cyc + int'(LAT) - 1);
        @(negedge clk);
        if (!rst_n) model_reset();
        xv = ev[cyc % 64];
        if (xv) hold = ed[cyc % 64];
        xd = hold;
        xm = em[cyc % 64];
        ev[cyc % 64] = 1'b0;
        em[cyc % 64] = 1'b0;
    endtask

    function automatic rq_t mk(input logic we, input logic [2:0] f, input logic [31:0] a,
                               input logic [31:0] d);
        rq_t r;
        r.req = 1'b1; r.we = we; r.f = f; r.a = a; r.d = d;
        return r;
    endfunction

    function automatic rq_t idle();
        rq_t r;
        r.req = 1'b0; r.we = 1'b0; r.f = 3'd0; r.a = '0; r.d = '0;
        return r;
    endfunction

    task automatic test_reset();
        logic xv, xm;
        logic [31:0] xd;
        rst_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step(mk(1'b0, 3'd2, 32'h10, 32'h0), xv, xd, xm);
            n_cmp++;
            if (bus.o_valid !== 1'b0 || bus.o_data !== 32'h0 || bus.o_misalign !== 1'b0) begin
                n_bad++;
                $display("FAIL reset_hold cyc=%0d got v=%b d=%h m=%b want v=0 d=0 m=0",
                         cyc, bus.o_valid, bus.o_data, bus.o_misalign);
            end
        end
        rst_n = 1'b1;
        for (int i = 0; i < int'(LAT) + 2; i++) begin
            step(idle(), xv, xd, xm);
            n_cmp++;
            if (bus.o_valid !== 1'b0 || bus.o_data !== 32'h0 || bus.o_misalign !== 1'b0) begin
                n_bad++;
                $display("FAIL reset_release cyc=%0d got v=%b d=%h m=%b want v=0 d=0 m=0",
                         cyc, bus.o_valid, bus.o_data, bus.o_misalign);
            end
        end
    endtask

    task automatic test_store_load();
        logic xv, xm;
        logic [31:0] xd;
        int seen = 0;
        step(mk(1'b1, 3'd2, 32'h10, 32'h8000_00FF), xv, xd, xm);
        for (int i = 1; i <= int'(LAT) + 2; i++) begin
            step((i == 1) ? mk(1'b0, 3'd2, 32'h10, 32'h0) : idle(), xv, xd, xm);
            n_cmp++;
            if (bus.o_valid !== xv || bus.o_data !== xd || bus.o_misalign !== xm) begin
                n_bad++;
                $display("FAIL sw_lw cyc=%0d got v=%b d=%h m=%b want v=%b d=%h m=%b",
                         cyc, bus.o_valid, bus.o_data, bus.o_misalign, xv, xd, xm);
            end
            if (bus.o_valid === 1'b1 && seen == 0) seen = i;
        end
        n_cmp++;
        if (seen != int'(LAT) || bus.o_data !== 32'h8000_00FF) begin
            n_bad++;
            $display("FAIL sw_lw_latency got lat=%0d d=%h want lat=%0d d=800000ff", seen, bus.o_data, LAT);
        end
    endtask

    task automatic test_byte();
        rq_t q[$];
        logic [31:0] got[$];
        logic [31:0] want[3];
        logic xv, xm;
        logic [31:0] xd;
        want[0] = 32'hAB22_3344; want[1] = 32'hFFFF_FFAB; want[2] = 32'h0000_00AB;
        q.push_back(mk(1'b1, 3'd2, 32'h10, 32'h1122_3344));
        q.push_back(mk(1'b1, 3'd0, 32'h13, 32'h0000_00AB));
        q.push_back(mk(1'b0, 3'd2, 32'h10, 32'h0));
        q.push_back(mk(1'b0, 3'd0, 32'h13, 32'h0));
        q.push_back(mk(1'b0, 3'd4, 32'h13, 32'h0));
        for (int i = 0; i < int'(LAT) + 1; i++) q.push_back(idle());
        foreach (q[i]) begin
            step(q[i], xv, xd, xm);
            n_cmp++;
            if (bus.o_valid !== xv || bus.o_data !== xd || bus.o_misalign !== xm) begin
                n_bad++;
                $display("FAIL byte_lane cyc=%0d got v=%b d=%h m=%b want v=%b d=%h m=%b",
                         cyc, bus.o_valid, bus.o_data, bus.o_misalign, xv, xd, xm);
            end
            if (bus.o_valid === 1'b1) got.push_back(bus.o_data);
        end
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (got.size() <= i || got[i] !== want[i]) begin
                n_bad++;
                $display("FAIL byte_result idx=%0d got %h want %h", i,
                         (got.size() > i) ? got[i] : 32'hx, want[i]);
            end
        end
    endtask

    task automatic test_half();
        rq_t q[$];
        logic [31:0] got[$];
        logic [31:0] want[4];
        logic xv, xm;
        logic [31:0] xd;
        int mis_seen = 0;
        want[0] = 32'hFFFF_8001; want[1] = 32'h0000_8001; want[2] = 32'h0; want[3] = 32'h8001_5678;
        q.push_back(mk(1'b1, 3'd2, 32'h20, 32'h1234_5678));
        q.push_back(mk(1'b1, 3'd1, 32'h22, 32'h0000_8001));
        q.push_back(mk(1'b0, 3'd1, 32'h22, 32'h0));
        q.push_back(mk(1'b0, 3'd5, 32'h22, 32'h0));
        q.push_back(mk(1'b0, 3'd1, 32'h21, 32'h0));
        q.push_back(mk(1'b1, 3'd1, 32'h21, 32'h0000_FFFF));
        q.push_back(mk(1'b0, 3'd2, 32'h20, 32'h0));
        for (int i = 0; i < int'(LAT) + 1; i++) q.push_back(idle());
        foreach (q[i]) begin
            step(q[i], xv, xd, xm);
            n_cmp++;
            if (bus.o_valid !== xv || bus.o_data !== xd || bus.o_misalign !== xm) begin
                n_bad++;
                $display("FAIL half_lane cyc=%0d got v=%b d=%h m=%b want v=%b d=%h m=%b",
                         cyc, bus.o_valid, bus.o_data, bus.o_misalign, xv, xd, xm);
            end
            if (bus.o_valid === 1'b1) got.push_back(bus.o_data);
            if (bus.o_misalign === 1'b1) mis_seen++;
        end
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (got.size() <= i || got[i] !== want[i]) begin
                n_bad++;
                $display("FAIL half_result idx=%0d got %h want %h", i,
                         (got.size() > i) ? got[i] : 32'hx, want[i]);
            end
        end
        n_cmp++;
        if (mis_seen != 2) begin
            n_bad++;
            $display("FAIL half_misalign_pulses got %0d want 2", mis_seen);
        end
    endtask

    task automatic test_back_to_back();
        rq_t q[$];
        int vcyc[$];
        int first_lw;
        logic xv, xm;
        logic [31:0] xd;
        for (int i = 0; i < 8; i++) q.push_back(mk(1'b1, 3'd2, 32'(4 * i), $urandom));
        for (int i = 0; i < 8; i++) q.push_back(mk(1'b0, 3'd2, 32'(4 * i), 32'h0));
        for (int i = 0; i < int'(LAT) + 1; i++) q.push_back(idle());
        first_lw = cyc + 9;
        foreach (q[i]) begin
            step(q[i], xv, xd, xm);
            n_cmp++;
            if (bus.o_valid !== xv || bus.o_data !== xd || bus.o_misalign !== xm) begin
                n_bad++;
                $display("FAIL b2b cyc=%0d got v=%b d=%h m=%b want v=%b d=%h m=%b",
                         cyc, bus.o_valid, bus.o_data, bus.o_misalign, xv, xd, xm);
            end
            if (bus.o_valid === 1'b1) vcyc.push_back(cyc);
        end
        n_cmp++;
        if (vcyc.size() != 8 || vcyc[0] != first_lw + int'(LAT) - 1 || vcyc[7] != vcyc[0] + 7) begin
            n_bad++;
            $display("FAIL b2b_timing got n=%0d first=%0d want n=8 first=%0d consecutive",
                     vcyc.size(), (vcyc.size() > 0) ? vcyc[0] : -1, first_lw + int'(LAT) - 1);
        end
    endtask

    task automatic test_random();
        logic xv, xm;
        logic [31:0] xd;
        rq_t r;
        for (int i = 0; i < 64; i++) begin
            step(mk(1'b1, 3'd2, 32'(4 * i), $urandom), xv, xd, xm);
        end
        for (int i = 0; i < 300 + int'(LAT) + 1; i++) begin
            r = idle();
            if (i < 300 && $urandom_range(0, 4) != 0) begin
                r = mk($urandom_range(0, 2) == 0, 3'($urandom_range(0, 7)),
                       ($urandom & 32'hFFFF_F000) | 32'($urandom_range(0, 255)), $urandom);
            end
            step(r, xv, xd, xm);
            n_cmp++;
            if (bus.o_valid !== xv || bus.o_data !== xd || bus.o_misalign !== xm) begin
                n_bad++;
                $display("FAIL random cyc=%0d got v=%b d=%h m=%b want v=%b d=%h m=%b",
                         cyc, bus.o_valid, bus.o_data, bus.o_misalign, xv, xd, xm);
            end
        end
    endtask

    task automatic test_reset_midflight();
        rq_t q[$];
        logic [31:0] got[$];
        logic [31:0] val;
        logic xv, xm;
        logic [31:0] xd;
        int vcount = 0;
        step(mk(1'b0, 3'd2, 32'h10, 32'h0), xv, xd, xm);
        if (bus.o_valid === 1'b1) vcount++;
        rst_n = 1'b0;
        step(mk(1'b0, 3'd2, 32'h14, 32'h0), xv, xd, xm);
        if (bus.o_valid === 1'b1) vcount++;
        step(idle(), xv, xd, xm);
        rst_n = 1'b1;
        for (int i = 0; i < int'(LAT) + 2; i++) begin
            step(idle(), xv, xd, xm);
            if (bus.o_valid === 1'b1) vcount++;
        end
        n_cmp++;
        if (vcount != 0 || bus.o_data !== 32'h0) begin
            n_bad++;
            $display("FAIL midflight_reset got valids=%0d d=%h want valids=0 d=0", vcount, bus.o_data);
        end
        val = $urandom;
        q.push_back(mk(1'b1, 3'd2, 32'(DEPTH * 4), val));
        q.push_back(mk(1'b0, 3'd2, 32'h0, 32'h0));
        for (int i = 0; i < int'(LAT) + 1; i++) q.push_back(idle());
        foreach (q[i]) begin
            step(q[i], xv, xd, xm);
            n_cmp++;
            if (bus.o_valid !== xv || bus.o_data !== xd || bus.o_misalign !== xm) begin
                n_bad++;
                $display("FAIL alias cyc=%0d got v=%b d=%h m=%b want v=%b d=%h m=%b",
                         cyc, bus.o_valid, bus.o_data, bus.o_misalign, xv, xd, xm);
            end
            if (bus.o_valid === 1'b1) got.push_back(bus.o_data);
        end
        n_cmp++;
        if (got.size() != 1 || got[0] !== val) begin
            n_bad++;
            $display("FAIL alias_value got n=%0d d=%h want n=1 d=%h", got.size(),
                     (got.size() > 0) ? got[0] : 32'hx, val);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout at cyc=%0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        model_reset();
        test_reset();
        test_store_load();
        test_byte();
        test_half();
        test_back_to_back();
        test_random();
        test_reset_midflight();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
